// File: rtl/tug_of_war_if.sv
// tug_of_war_if: player keys (LeftButton, RightButton) in; playfield LEDR[9:0] and active-low winner digit display[6:0] out
interface tug_of_war_if;
  logic       LeftButton;
  logic       RightButton;
  logic [9:0] LEDR;
  logic [6:0] display;
  modport master (output LeftButton, RightButton, input LEDR, display);
  modport slave (input LeftButton, RightButton, output LEDR, display);
endinterface

// File: rtl/tug_of_war.sv
// tug_of_war: 9-light tug-of-war; clock/reset (sync, active-high), io.slave carries keys in and LEDR/display out
module tug_of_war (
  input  logic         clock,
  input  logic         reset,
  tug_of_war_if.slave  io
);
  typedef enum logic [1:0] {NONE, LEFT_WIN, RIGHT_WIN} win_t;
  win_t       win_q, win_d;
  logic [9:1] led_q, led_d;
  logic [10:0] ext;
  logic       l, r;
  assign l = io.LeftButton & ~io.RightButton & (win_q == NONE);
  assign r = io.RightButton & ~io.LeftButton & (win_q == NONE);
  assign ext = {1'b0, led_q, 1'b0};
  always_comb begin
    led_d = led_q;
    for (int i = 1; i <= 9; i++)
      led_d[i] = (l & ext[i-1]) | (r & ext[i+1]) | (ext[i] & ~(l | r));
  end
  always_comb begin
    win_d = win_q;
    if (win_q == NONE)
      win_d = (led_q[9] & l) ? LEFT_WIN : (led_q[1] & r) ? RIGHT_WIN : NONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q <= 9'b000010000;
      win_q <= NONE;
    end else begin
      led_q <= led_d;
      win_q <= win_d;
    end
  end
  assign io.LEDR = {led_q, 1'b0};
  assign io.display = (win_q == LEFT_WIN) ? 7'b0100100 : (win_q == RIGHT_WIN) ? 7'b1111001 : 7'b1111111;
endmodule

// File: tb/tb_tug_of_war.sv
// tb_tug_of_war: table-driven scoreboard bench for tug_of_war
module tb_tug_of_war;
  logic clock = 0;
  logic reset;
  int total = 0;
  int bad = 0;
  tug_of_war_if io ();
  tug_of_war dut (.clock(clock), .reset(reset), .io(io));
  always #5 clock = ~clock;
  typedef struct {
    logic       rst;
    logic       lb;
    logic       rb;
    logic [9:0] led;
    logic [6:0] disp;
  } vec_t;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] ONE   = 7'b1111001;
  localparam logic [6:0] TWO   = 7'b0100100;
  localparam logic [9:0] CTR   = 10'b0000100000;
  vec_t tbl[24];
  logic [16:0] sb[$];
  task automatic step(input string name, input logic rs, input logic lb, input logic rb,
                      input logic [9:0] led, input logic [6:0] disp);
    logic [16:0] e;
    @(negedge clock);
    reset = rs;
    io.LeftButton = lb;
    io.RightButton = rb;
    sb.push_back({led, disp});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    total++;
    if ({io.LEDR, io.display} !== e) begin
      bad++;
      $display("FAIL %s: got LEDR=%b display=%b, want LEDR=%b display=%b",
               name, io.LEDR, io.display, e[16:7], e[6:0]);
    end
  endtask
  initial begin
    tbl[0]  = '{1, 0, 0, CTR, BLANK};
    tbl[1]  = '{0, 0, 1, 10'b0000010000, BLANK};
    tbl[2]  = '{0, 0, 1, 10'b0000001000, BLANK};
    tbl[3]  = '{0, 1, 0, 10'b0000010000, BLANK};
    tbl[4]  = '{0, 1, 0, CTR, BLANK};
    tbl[5]  = '{0, 1, 1, CTR, BLANK};
    tbl[6]  = '{0, 1, 1, CTR, BLANK};
    tbl[7]  = '{0, 1, 1, CTR, BLANK};
    tbl[8]  = '{0, 0, 0, CTR, BLANK};
    tbl[9]  = '{0, 0, 1, 10'b0000010000, BLANK};
    tbl[10] = '{0, 0, 1, 10'b0000001000, BLANK};
    tbl[11] = '{0, 0, 1, 10'b0000000100, BLANK};
    tbl[12] = '{0, 0, 1, 10'b0000000010, BLANK};
    tbl[13] = '{0, 0, 1, 10'b0000000000, ONE};
    tbl[14] = '{0, 0, 1, 10'b0000000000, ONE};
    tbl[15] = '{0, 1, 0, 10'b0000000000, ONE};
    tbl[16] = '{1, 0, 0, CTR, BLANK};
    tbl[17] = '{0, 1, 0, 10'b0001000000, BLANK};
    tbl[18] = '{0, 1, 0, 10'b0010000000, BLANK};
    tbl[19] = '{0, 1, 0, 10'b0100000000, BLANK};
    tbl[20] = '{0, 1, 0, 10'b1000000000, BLANK};
    tbl[21] = '{0, 1, 0, 10'b0000000000, TWO};
    tbl[22] = '{0, 0, 1, 10'b0000000000, TWO};
    tbl[23] = '{1, 1, 0, CTR, BLANK};
    reset = 1;
    io.LeftButton = 0;
    io.RightButton = 0;
    for (int i = 0; i < 24; i++)
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].lb, tbl[i].rb, tbl[i].led, tbl[i].disp);
    step("mid_l1", 0, 1, 0, 10'b0001000000, BLANK);
    step("mid_l2", 0, 1, 0, 10'b0010000000, BLANK);
    step("mid_rst", 1, 1, 0, CTR, BLANK);
    for (int i = 0; i < 4; i++)
      step($sformatf("edge_r%0d", i), 0, 0, 1, CTR >> (i + 1), BLANK);
    step("edge_both1", 0, 1, 1, 10'b0000000010, BLANK);
    step("edge_both2", 0, 1, 1, 10'b0000000010, BLANK);
    step("edge_none", 0, 0, 0, 10'b0000000010, BLANK);
    step("edge_back", 0, 1, 0, 10'b0000000100, BLANK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tug_of_war.md
Name: tug_of_war

Overview:
- Two-player tug-of-war game on a 9-light playfield, LEDR[9:1], with a seven-segment winner display.
- The playfield is built from one centerLight cell at position 5 and eight normalLight cells at positions 9..6 and 4..1.
- A Winner unit detects when the light is pushed off either end and latches the result onto the display.
- The block sits directly between the debounced/synchronised player key inputs and the board LEDs/HEX digit.

Parameters:
- None. Playfield size is fixed at 9 lights and the center is fixed at LEDR[5].

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- LeftButton  input  1  left player key, level-sensitive, active-high, already synchronised.
- RightButton  input  1  right player key, level-sensitive, active-high, already synchronised.
- LEDR  output  10  playfield lights. LEDR[9] is the left end, LEDR[1] is the right end. LEDR[0] is constant 0.
- display  output  7  active-low seven-segment code, segments {g,f,e,d,c,b,a}, showing the winner.

Behaviour:
- One clock; reset is synchronous and active-high. All state is registered, with no combinational path from the buttons to the outputs.
- Move definitions:
  - L = LeftButton & ~RightButton.
  - R = RightButton & ~LeftButton.
  - Both keys high, or both low, is no move.
  - The keys are level-sensitive: every clock a key is held alone produces one step. There is no edge detection in this block.
- Light cell i, one state bit. Neighbours:
  - leftN is LEDR[i+1]; it is 0 for cell 9.
  - rightN is LEDR[i-1]; it is 0 for cell 1.
- Light cell next-state, in priority order:
  - L & rightN -> on (the light moves left).
  - R & leftN -> on (the light moves right).
  - on & (L | R) -> off.
  - otherwise -> hold.
- Reset values: centerLight (LEDR[5]) = 1. All normalLight cells = 0. This gives LEDR = 10'b0000100000 after reset.
- Exactly one light is lit at any time during play. The light moves one position per move cycle.
- Win detection, evaluated every clock while no winner is latched:
  - LEDR[9] & L -> left player wins.
  - LEDR[1] & R -> right player wins.
- On the winning edge the end light turns off (no neighbour feeds it). The playfield therefore goes all-zero and stays all-zero until reset.
- Winner state machine: NONE, LEFT_WIN, RIGHT_WIN.
  - reset -> NONE.
  - NONE -> LEFT_WIN or RIGHT_WIN on the conditions above.
  - LEFT_WIN and RIGHT_WIN are sticky until reset, and all buttons are ignored.
- display is driven from the registered winner state:
  - NONE = 7'b1111111 (blank).
  - RIGHT_WIN = 7'b1111001 ("1").
  - LEFT_WIN = 7'b0100100 ("2").
- Latency:
  - A light moves on the first rising edge at which the move is sampled.
  - display changes on the same edge that clears the end light.
- Reset mid-game, or after a win, restores the center light and blanks the display on the next edge.
- Both buttons held, or no buttons held, means no change anywhere, including at the end positions.

Test Plan:
- Reset asserted for 1 cycle -> LEDR = 10'b0000100000, display = 7'b1111111.
- From reset, RightButton=1 alone for 2 cycles -> LEDR[4] lit, then LEDR[3] lit; display stays blank.
- Then LeftButton=1 alone for 2 cycles -> LEDR[4], then LEDR[5]. Both buttons =1 for 3 cycles -> LEDR[5] stays lit.
- From center, RightButton held for 5 cycles -> light at LEDR[4], [3], [2], [1] in turn. On the 5th edge LEDR = 0 and display = 7'b1111001. Holding keys afterwards leaves both unchanged.
- From center, LeftButton held for 5 cycles -> light at LEDR[6]..[9] in turn. On the 5th edge LEDR = 0 and display = 7'b0100100.
- After either win, assert reset for 1 cycle -> LEDR = 10'b0000100000, display blank. Reset asserted mid-move (light at LEDR[7]) -> center restored on that edge.
